mem_write_scheduler: RTL and testbench

//  Upstream feeder for the 32x16 dual-write-port register memory. Accepts write requests from two

---
 rtl/mem_write_scheduler.sv | 167 ++++++++++++++++
 tb/tb_mem_write_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_write_scheduler.sv
// mem_write_scheduler
//   Feeds the two write ports of a 32x16 dual-write-port register memory from
//   two independent valid/ready request channels. Each channel has its own
//   FIFO; heads are issued onto the matching write port. When both heads
//   target the same word, channel 1 goes first and channel 2 follows a cycle
//   later, so channel 2's value is the one left in the memory.
//   The memory's clock-gating enable is held high while anything is pending,
//   while a write is being issued, and for HOLD_CYCLES cycles afterwards.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req1_valid/ready/addr/data    channel 1 request (ready = FIFO not full)
//   req2_valid/ready/addr/data    channel 2 request (ready = FIFO not full)
//   wr1_en/addr/data              registered memory write port 1
//   wr2_en/addr/data              registered memory write port 2
//   mem_enable                    registered memory clock-gating enable
//   busy                          a FIFO holds data or a write is on a port
module mem_write_scheduler #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_addr,
    input  logic [31:0] req1_data,
    input  logic        req2_valid,
    output logic        req2_ready,
    input  logic [3:0]  req2_addr,
    input  logic [31:0] req2_data,
    output logic        wr1_en,
    output logic [3:0]  wr1_addr,
    output logic [31:0] wr1_data,
    output logic        wr2_en,
    output logic [3:0]  wr2_addr,
    output logic [31:0] wr2_data,
    output logic        mem_enable,
    output logic        busy
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = 36;    // {addr[3:0], data[31:0]}

    logic [1:0]              in_valid;
    logic [1:0]              in_ready;
    logic [1:0]              push;
    logic [1:0]              pop;
    logic [1:0]              nonempty;
    logic [1:0][ENTRY_W-1:0] in_entry;
    logic [1:0][ENTRY_W-1:0] head;

    assign in_valid = {req2_valid, req1_valid};
    assign in_entry = {{req2_addr, req2_data}, {req1_addr, req1_data}};
    assign req1_ready = in_ready[0];
    assign req2_ready = in_ready[1];

    // One FIFO per channel. Ready depends only on occupancy, so a full FIFO
    // that is popping this cycle still refuses a new beat.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [ENTRY_W-1:0] store_q [DEPTH];
            logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
            logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
            logic [CNT_W-1:0]   count_q, count_d;

            assign in_ready[gi] = (count_q != CNT_W'(DEPTH));
            assign nonempty[gi] = (count_q != '0);
            assign push[gi]     = in_valid[gi] & in_ready[gi];
            assign head[gi]     = store_q[rd_ptr_q];

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (push[gi]) wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (pop[gi])  rd_ptr_d = rd_ptr_q + PTR_W'(1);
                case ({push[gi], pop[gi]})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            // Storage needs no reset: the pointers define what is valid.
            always_ff @(posedge clk) begin
                if (push[gi]) store_q[wr_ptr_q] <= in_entry[gi];
            end
        end
    endgenerate

    logic [1:0]        wr_en_q, wr_en_d;
    logic [1:0][3:0]   wr_addr_q, wr_addr_d;
    logic [1:0][31:0]  wr_data_q, wr_data_d;
    logic [3:0]        hold_cnt_q, hold_cnt_d;
    logic              mem_enable_q, mem_enable_d;

    // Issue: channel 1 always drains when it has a head; channel 2 yields
    // for one cycle when its head targets the same word as channel 1's.
    always_comb begin
        pop    = '0;
        pop[0] = nonempty[0];
        pop[1] = nonempty[1] &
                 (~nonempty[0] | (head[0][ENTRY_W-1:32] != head[1][ENTRY_W-1:32]));
    end

    always_comb begin
        wr_en_d   = pop;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        for (int i = 0; i < 2; i++) begin
            if (pop[i]) begin
                wr_addr_d[i] = head[i][ENTRY_W-1:32];
                wr_data_d[i] = head[i][31:0];
            end
        end

        if (|pop)
            hold_cnt_d = 4'(HOLD_CYCLES);
        else if (hold_cnt_q != '0)
            hold_cnt_d = hold_cnt_q - 4'd1;
        else
            hold_cnt_d = hold_cnt_q;

        // Rises together with the first wrN_en, so the memory is already
        // clocked at the edge where it captures that write.
        mem_enable_d = (|nonempty) | (|pop) | (hold_cnt_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q      <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            hold_cnt_q   <= '0;
            mem_enable_q <= 1'b0;
        end else begin
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            hold_cnt_q   <= hold_cnt_d;
            mem_enable_q <= mem_enable_d;
        end
    end

    assign wr1_en     = wr_en_q[0];
    assign wr1_addr   = wr_addr_q[0];
    assign wr1_data   = wr_data_q[0];
    assign wr2_en     = wr_en_q[1];
    assign wr2_addr   = wr_addr_q[1];
    assign wr2_data   = wr_data_q[1];
    assign mem_enable = mem_enable_q;
    assign busy       = (|nonempty) | (|wr_en_q);
endmodule

// File: tb/tb_mem_write_scheduler.sv
module tb_mem_write_scheduler;
    localparam int DEPTH = 4;
    localparam int HOLD  = 2;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req1_valid, req2_valid;
    logic        req1_ready, req2_ready;
    logic [3:0]  req1_addr = '0, req2_addr = '0;
    logic [31:0] req1_data = '0, req2_data = '0;
    logic        wr1_en, wr2_en, mem_enable, busy;
    logic [3:0]  wr1_addr, wr2_addr;
    logic [31:0] wr1_data, wr2_data;

    mem_write_scheduler #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_addr(req1_addr), .req1_data(req1_data),
        .req2_valid(req2_valid), .req2_ready(req2_ready),
        .req2_addr(req2_addr), .req2_data(req2_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .wr2_en(wr2_en), .wr2_addr(wr2_addr), .wr2_data(wr2_data),
        .mem_enable(mem_enable), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- stimulus drivers ----------------
    beat_t stim1[$], stim2[$];
    int    rate1 = 100, rate2 = 100;
    logic  rdy1_s = 1'b0, rdy2_s = 1'b0;

    initial forever begin
        @(negedge clk);
        rdy1_s = req1_ready;
        rdy2_s = req2_ready;
    end

    initial begin
        bit acc;
        req1_valid = 1'b0;
        forever begin
            @(posedge clk);
            acc = req1_valid && rdy1_s;
            if (acc && stim1.size() > 0) void'(stim1.pop_front());
            #1;
            if (stim1.size() > 0 && ((req1_valid && !acc) || $urandom_range(0, 99) < rate1)) begin
                req1_valid = 1'b1;
                req1_addr  = stim1[0].addr;
                req1_data  = stim1[0].data;
            end else begin
                req1_valid = 1'b0;
            end
        end
    end

    initial begin
        bit acc;
        req2_valid = 1'b0;
        forever begin
            @(posedge clk);
            acc = req2_valid && rdy2_s;
            if (acc && stim2.size() > 0) void'(stim2.pop_front());
            #1;
            if (stim2.size() > 0 && ((req2_valid && !acc) || $urandom_range(0, 99) < rate2)) begin
                req2_valid = 1'b1;
                req2_addr  = stim2[0].addr;
                req2_data  = stim2[0].data;
            end else begin
                req2_valid = 1'b0;
            end
        end
    end

    // ---------------- memory fed by the DUT ----------------
    logic [31:0] dut_mem [16];
    initial begin
        for (int i = 0; i < 16; i++) dut_mem[i] = '0;
        forever begin
            @(posedge clk);
            if (mem_enable && wr1_en) dut_mem[wr1_addr] = wr1_data;
            if (mem_enable && wr2_en) dut_mem[wr2_addr] = wr2_data;
        end
    end

    // ---------------- behavioural model ----------------
    beat_t       mq1[$], mq2[$];
    logic [31:0] model_mem [16];
    bit          model_on = 0;
    bit          exp_en1, exp_en2, exp_mem_en, exp_busy, exp_rdy1, exp_rdy2;
    logic [3:0]  exp_addr1, exp_addr2;
    logic [31:0] exp_data1, exp_data2;
    int          cyc = 0, last_issue = 0;
    bit          has_issue = 0;

    task automatic model_step();
        beat_t b;
        bit acc1, acc2, p1, p2, pending, hold_live;
        cyc++;
        if (rst) begin
            mq1.delete(); mq2.delete();
            exp_en1 = 0; exp_en2 = 0;
            exp_addr1 = '0; exp_addr2 = '0; exp_data1 = '0; exp_data2 = '0;
            exp_mem_en = 0; has_issue = 0; model_on = 1;
        end else begin
            acc1 = req1_valid && (mq1.size() < DEPTH);
            acc2 = req2_valid && (mq2.size() < DEPTH);
            pending = (mq1.size() > 0) || (mq2.size() > 0);
            hold_live = has_issue && (cyc - last_issue <= HOLD);
            p1 = mq1.size() > 0;
            p2 = (mq2.size() > 0) && (!p1 || mq1[0].addr != mq2[0].addr);
            exp_en1 = p1;
            exp_en2 = p2;
            if (p1) begin
                b = mq1.pop_front();
                exp_addr1 = b.addr; exp_data1 = b.data;
                model_mem[b.addr] = b.data;
            end
            if (p2) begin
                b = mq2.pop_front();
                exp_addr2 = b.addr; exp_data2 = b.data;
                model_mem[b.addr] = b.data;
            end
            if (acc1) mq1.push_back({req1_addr, req1_data});
            if (acc2) mq2.push_back({req2_addr, req2_data});
            if (p1 || p2) begin
                has_issue = 1;
                last_issue = cyc;
            end
            exp_mem_en = pending || p1 || p2 || hold_live;
        end
        exp_busy = (mq1.size() > 0) || (mq2.size() > 0) || exp_en1 || exp_en2;
        exp_rdy1 = mq1.size() < DEPTH;
        exp_rdy2 = mq2.size() < DEPTH;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (model_on) begin
            check("wr1_en", wr1_en, exp_en1);
            check("wr2_en", wr2_en, exp_en2);
            check("wr1_addr", wr1_addr, exp_addr1);
            check("wr1_data", wr1_data, exp_data1);
            check("wr2_addr", wr2_addr, exp_addr2);
            check("wr2_data", wr2_data, exp_data2);
            check("mem_enable", mem_enable, exp_mem_en);
            check("busy", busy, exp_busy);
            check("req1_ready", req1_ready, exp_rdy1);
            check("req2_ready", req2_ready, exp_rdy2);
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_idle(input string name, input int max_cycles);
        bit ok = 0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (stim1.size() == 0 && stim2.size() == 0 && !busy && !mem_enable) begin
                ok = 1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.addr = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        b.data = $urandom;
        return b;
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        bit any_wr;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_wr1_en", wr1_en, 0);
        check("rst_mem_en", mem_enable, 0);
        check("rst_busy", busy, 0);
        check("rst_ready1", req1_ready, 1);

        // Single write on channel 1: latency and hold-off.
        @(posedge clk);
        stim1.push_back({4'd3, 32'hDEADBEEF});
        @(negedge clk); @(negedge clk);               // after accept edge E
        check("t1_wr1_en_E", wr1_en, 0);
        check("t1_mem_en_E", mem_enable, 0);
        @(negedge clk);                               // after E+1
        check("t1_wr1_en", wr1_en, 1);
        check("t1_wr1_addr", wr1_addr, 4'd3);
        check("t1_wr1_data", wr1_data, 32'hDEADBEEF);
        check("t1_mem_en", mem_enable, 1);
        @(negedge clk);                               // after E+2
        check("t1_wr1_en_off", wr1_en, 0);
        check("t1_mem_en_h1", mem_enable, 1);
        @(negedge clk);                               // after E+3
        check("t1_mem_en_h2", mem_enable, 1);
        @(negedge clk);                               // after E+4
        check("t1_mem_en_drop", mem_enable, 0);

        // Different addresses issue together.
        @(posedge clk);
        stim1.push_back({4'd5, 32'h11});
        stim2.push_back({4'd9, 32'h22});
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("t2_wr1_en", wr1_en, 1);
        check("t2_wr2_en", wr2_en, 1);
        check("t2_wr1", {wr1_addr, wr1_data}, {4'd5, 32'h11});
        check("t2_wr2", {wr2_addr, wr2_data}, {4'd9, 32'h22});
        wait_idle("t2_idle", 50);

        // Same address: channel 1 then channel 2.
        @(posedge clk);
        stim1.push_back({4'd7, 32'hAAAA});
        stim2.push_back({4'd7, 32'hBBBB});
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("t3_wr1", {wr1_en, wr1_addr, wr1_data}, {1'b1, 4'd7, 32'hAAAA});
        check("t3_wr2_en_t", wr2_en, 0);
        @(negedge clk);
        check("t3_wr2", {wr2_en, wr2_addr, wr2_data}, {1'b1, 4'd7, 32'hBBBB});
        check("t3_wr1_en_t1", wr1_en, 0);
        @(negedge clk);
        check("t3_mem7", dut_mem[7], 32'hBBBB);
        wait_idle("t3_idle", 50);

        // Back-to-back collisions stall channel 2 until its FIFO fills.
        @(posedge clk);
        for (int i = 0; i < 6; i++) begin
            stim1.push_back({4'd7, 32'h1000 + 32'(i)});
            stim2.push_back({4'd7, 32'h2000 + 32'(i)});
        end
        @(negedge clk);
        repeat (3) @(negedge clk);                    // after E+2
        check("t4_ready2_3q", req2_ready, 1);
        @(negedge clk);                               // after E+3
        check("t4_ready2_full", req2_ready, 0);
        @(negedge clk); @(negedge clk);               // after E+5
        check("t4_ready2_still", req2_ready, 0);
        wait_idle("t4_idle", 80);
        check("t4_mem7", dut_mem[7], 32'h2005);

        // Reset with entries queued discards them.
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            stim1.push_back({4'd2, 32'h3000 + 32'(i)});
            stim2.push_back({4'd2, 32'h4000 + 32'(i)});
        end
        repeat (3) @(posedge clk);                    // at edge E+2
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("t5_wr_en", {wr1_en, wr2_en}, 2'b00);
        check("t5_mem_en", mem_enable, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", {req1_ready, req2_ready}, 2'b11);
        any_wr = 0;
        repeat (8) begin
            @(negedge clk);
            if (wr1_en || wr2_en) any_wr = 1;
        end
        check("t5_no_issue", any_wr, 0);

        // Random traffic.
        rate1 = 60; rate2 = 60;
        for (int i = 0; i < 1500; i++) begin
            stim1.push_back(rand_beat());
            stim2.push_back(rand_beat());
        end
        repeat (2000) @(negedge clk);
        stim1.delete(); stim2.delete();
        wait_idle("t6_idle", 60);
        for (int a = 0; a < 16; a++)
            check($sformatf("t6_mem%0d", a), dut_mem[a], model_mem[a]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
